uart_tx_fifo: RTL
=================

Name: uart_tx_fifo

Overview:
- Transmit-side elastic buffer directly upstream of the UART transmitter.
- Host writes bytes at its own rate. The block stores them and feeds the transmitter one frame at a time.
- Each frame is issued as a one-cycle valid pulse with parallel data. The next frame waits until the transmitter's busy flag has risen and then fallen.
- Sits in the TX clock domain; the host side is synchronous to the same clock.

Parameters:
- DATA_WIDTH, 8, width of each entry and of the parallel data to the transmitter.
- DEPTH, 16, number of entries; power of two, at least 2.
- START_TIMEOUT, 4, cycles to wait for busy to rise after a launch before abandoning the wait.

Ports:
- CLK  input  1  TX clock; all logic on rising edge.
- RST  input  1  synchronous, active-high reset.
- WR_DATA  input  DATA_WIDTH  byte to enqueue.
- WR_EN  input  1  enqueue strobe, sampled every edge.
- FULL  output  1  count == DEPTH.
- EMPTY  output  1  count == 0.
- COUNT  output  $clog2(DEPTH)+1  current occupancy.
- OVERFLOW  output  1  one-cycle pulse when a write is dropped.
- TX_P_DATA  output  DATA_WIDTH  parallel data to the transmitter.
- TX_DATA_VALID  output  1  one-cycle launch pulse to the transmitter.
- TX_BUSY  input  1  transmitter busy flag.

Behaviour:
- Reset (synchronous, RST high at an edge):
  - Pointers, COUNT, OVERFLOW, TX_P_DATA and TX_DATA_VALID go to 0.
  - EMPTY goes to 1, FULL to 0, and the state machine to IDLE.
  - Reset mid-frame drops all stored entries. TX_DATA_VALID is low from the next cycle.
- All outputs are registered; FULL, EMPTY and COUNT derive from the occupancy register.
- Write:
  - WR_EN is accepted if COUNT < DEPTH, or if a pop occurs in the same edge.
  - Write while full with no same-edge pop: data is dropped, COUNT is unchanged, OVERFLOW is high for the following cycle.
- Pointers are $clog2(DEPTH) bits and wrap naturally.
- Simultaneous push and pop: COUNT is unchanged and both pointers advance.
- State machine:
  - IDLE: if COUNT != 0 and TX_BUSY == 0 at an edge, then:
    - TX_P_DATA <= the head entry, and TX_DATA_VALID <= 1 for exactly one cycle;
    - the read pointer advances and COUNT decrements (the pop);
    - the timeout counter clears and the state goes to WAIT_BUSY.
  - WAIT_BUSY:
    - If TX_BUSY == 1, go to WAIT_DONE.
    - Otherwise the timeout counter increments. When it reaches START_TIMEOUT, go to IDLE; the popped frame is considered consumed.
  - WAIT_DONE: when TX_BUSY == 0, go to IDLE.
- Latency: a write at edge k into an empty FIFO with an idle transmitter gives TX_DATA_VALID high during the cycle after edge k+1.
- Back-to-back throughput: one frame per transmitter busy period plus 1 idle cycle.
- TX_P_DATA holds its last value between launches.
- TX_BUSY already high while IDLE: no launch until it falls.

Optional Feature:
- Macro: UART_TX_FIFO_STATS_EN.
- Defined — two extra outputs:
  - DROP_COUNT[7:0]: saturating at 255, increments on each OVERFLOW.
  - FRAMES_SENT[15:0]: wrapping, increments on each TX_DATA_VALID pulse.
  - Both reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package uart_pkg holds:
  - the typedef enum for the launch FSM states (IDLE, WAIT_BUSY, WAIT_DONE);
  - the default DATA_WIDTH constant;
  - the default START_TIMEOUT constant.
- Sub-module uart_sync_fifo: storage array, pointers, count and the FULL/EMPTY/OVERFLOW logic.
- The top level holds the launch FSM and timeout counter.

Test Plan:
- Reset then idle: RST high 2 cycles -> EMPTY=1, FULL=0, COUNT=0, TX_DATA_VALID=0, TX_P_DATA=0.
- Single frame: write 0xA5 at edge k with TX_BUSY=0; model busy rises 1 cycle after valid, lasts 10 cycles -> exactly one TX_DATA_VALID pulse after edge k+1 with TX_P_DATA=0xA5, COUNT returns to 0.
- Burst and order: write 0x01..0x10 (16) on consecutive cycles with TX_BUSY forced high -> FULL=1, COUNT=16, no valid pulse. Then release the busy model -> 16 launches in order 0x01..0x10, each only after busy fell.
- Overflow: with FIFO full and no pop, write 0xFF -> OVERFLOW high one cycle, COUNT stays 16, 0xFF never transmitted. With the macro, DROP_COUNT=1.
- Timeout: launch while busy never rises -> after 4 cycles in WAIT_BUSY, FSM returns to IDLE and launches the next entry.
- Reset mid-frame: RST asserted in WAIT_DONE with COUNT=5 -> next cycle COUNT=0, EMPTY=1, no further valid pulses after release until a new write.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and default constants for the UART transmit-side FIFO.
package uart_pkg;

    localparam int DATA_WIDTH_DEFAULT    = 8;
    localparam int START_TIMEOUT_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2
    } launch_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO: storage, wrapping pointers, occupancy and full/empty/overflow flags.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int DEPTH      = 16
) (
    input  logic                    clk,
    input  logic                    srst,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    wr_en,
    input  logic                    pop,
    output logic [DATA_WIDTH-1:0]   head_data,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             full_reg, full_next;
    logic             empty_reg, empty_next;
    logic             overflow_reg, overflow_next;
    logic             push_ok;
    logic             pop_ok;

    // A pop on the same edge frees the slot, so a write to a full FIFO still lands.
    assign pop_ok  = pop && !empty_reg;
    assign push_ok = wr_en && (!full_reg || pop_ok);

    always_comb begin
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        count_next    = count_reg;
        overflow_next = wr_en && !push_ok;
        if (push_ok) begin
            wr_ptr_next = wr_ptr_reg + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_next = rd_ptr_reg + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
        full_next  = (count_next == CNT_W'(DEPTH));
        empty_next = (count_next == '0);
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            full_reg     <= 1'b0;
            empty_reg    <= 1'b1;
            overflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            full_reg     <= full_next;
            empty_reg    <= empty_next;
            overflow_reg <= overflow_next;
        end
    end

    // Storage is not reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    // Head is read asynchronously so the launch edge can capture it into the output register.
    assign head_data = mem[rd_ptr_reg];
    assign full      = full_reg;
    assign empty     = empty_reg;
    assign count     = count_reg;
    assign overflow  = overflow_reg;

endmodule

// File: rtl/uart_tx_fifo.sv
// Elastic TX buffer feeding a UART transmitter one frame per busy period.
// Define UART_TX_FIFO_STATS_EN to add the DROP_COUNT / FRAMES_SENT statistics outputs.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH    = DATA_WIDTH_DEFAULT,
    parameter int DEPTH         = 16,
    parameter int START_TIMEOUT = START_TIMEOUT_DEFAULT
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [DATA_WIDTH-1:0]   WR_DATA,
    input  logic                    WR_EN,
    output logic                    FULL,
    output logic                    EMPTY,
    output logic [$clog2(DEPTH):0]  COUNT,
    output logic                    OVERFLOW,
    output logic [DATA_WIDTH-1:0]   TX_P_DATA,
    output logic                    TX_DATA_VALID,
`ifdef UART_TX_FIFO_STATS_EN
    output logic [7:0]              DROP_COUNT,
    output logic [15:0]             FRAMES_SENT,
`endif
    input  logic                    TX_BUSY
);

    localparam int TIMER_W = $clog2(START_TIMEOUT + 1);

    launch_state_t         state_reg, state_next;
    logic [TIMER_W-1:0]    timer_reg, timer_next;
    logic                  tx_valid_reg, tx_valid_next;
    logic [DATA_WIDTH-1:0] tx_data_reg, tx_data_next;
    logic                  pop;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  fifo_empty;
    logic                  fifo_overflow;

    uart_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk        (CLK),
        .srst       (RST),
        .wr_data    (WR_DATA),
        .wr_en      (WR_EN),
        .pop        (pop),
        .head_data  (head_data),
        .full       (FULL),
        .empty      (fifo_empty),
        .count      (COUNT),
        .overflow   (fifo_overflow)
    );

    always_comb begin
        state_next    = state_reg;
        timer_next    = timer_reg;
        tx_valid_next = 1'b0;
        tx_data_next  = tx_data_reg;
        pop           = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!fifo_empty && !TX_BUSY) begin
                    pop           = 1'b1;
                    tx_valid_next = 1'b1;
                    tx_data_next  = head_data;
                    timer_next    = '0;
                    state_next    = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (TX_BUSY) begin
                    state_next = WAIT_DONE;
                end else begin
                    timer_next = timer_reg + 1'b1;
                    // Transmitter never acknowledged: treat the frame as consumed.
                    if (timer_reg == TIMER_W'(START_TIMEOUT - 1)) begin
                        state_next = IDLE;
                    end
                end
            end
            WAIT_DONE: begin
                if (!TX_BUSY) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg    <= IDLE;
            timer_reg    <= '0;
            tx_valid_reg <= 1'b0;
            tx_data_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            timer_reg    <= timer_next;
            tx_valid_reg <= tx_valid_next;
            tx_data_reg  <= tx_data_next;
        end
    end

    assign EMPTY         = fifo_empty;
    assign OVERFLOW      = fifo_overflow;
    assign TX_P_DATA     = tx_data_reg;
    assign TX_DATA_VALID = tx_valid_reg;

`ifdef UART_TX_FIFO_STATS_EN
    logic [7:0]  drop_count_reg;
    logic [15:0] frames_sent_reg;

    always_ff @(posedge CLK) begin
        if (RST) begin
            drop_count_reg  <= '0;
            frames_sent_reg <= '0;
        end else begin
            if (fifo_overflow && drop_count_reg != 8'hFF) begin
                drop_count_reg <= drop_count_reg + 1'b1;
            end
            if (tx_valid_reg) begin
                frames_sent_reg <= frames_sent_reg + 1'b1;
            end
        end
    end

    assign DROP_COUNT  = drop_count_reg;
    assign FRAMES_SENT = frames_sent_reg;
`endif

endmodule
